axil_cfg_responder: RTL and testbench
=====================================

// Module: axil_cfg_responder
// PURPOSE
//  Synthesizable AXI4-Lite responder: the slave end of the host config port the garnet_test bench drives.
//  Terminates axi4_slave_* channels, holds a small local control/interrupt register bank, and forwards all
//  other addresses to a single-outstanding internal cfg bus toward the GLB/CGRA config fabric.
//  Sits between the SoC pad-frame AXI pins and the global-buffer/CGRA configuration logic.
// PARAMETERS
//  ADDR_WIDTH   CGRA_AXI_ADDR_WIDTH  AXI and cfg address width
//  DATA_WIDTH   CGRA_AXI_DATA_WIDTH  AXI and cfg data width (32)
//  IRQ_WIDTH    4                    number of interrupt sources
//  CFG_TIMEOUT  255                  max cycles waiting for cfg_rd_data_valid before SLVERR
//  ID_VALUE     32'h4741_524E        constant returned by ID register
// PORTS
//  clk                 in   1           clock
//  reset_n             in   1           asynchronous reset, active low
//  axi4_slave_awaddr   in   ADDR_WIDTH  write address
//  axi4_slave_awvalid  in   1           / axi4_slave_awready  out  1
//  axi4_slave_wdata    in   DATA_WIDTH  write data
//  axi4_slave_wvalid   in   1           / axi4_slave_wready   out  1
//  axi4_slave_bresp    out  2           write response
//  axi4_slave_bvalid   out  1           / axi4_slave_bready   in   1
//  axi4_slave_araddr   in   ADDR_WIDTH  read address
//  axi4_slave_arvalid  in   1           / axi4_slave_arready  out  1
//  axi4_slave_rdata    out  DATA_WIDTH  read data
//  axi4_slave_rresp    out  2           read response
//  axi4_slave_rvalid   out  1           / axi4_slave_rready   in   1
//  cfg_wr_en / cfg_rd_en  out 1         one-cycle request pulses (never both high)
//  cfg_addr            out  ADDR_WIDTH  forwarded address
//  cfg_wr_data         out  DATA_WIDTH  forwarded write data
//  cfg_rd_data         in   DATA_WIDTH  forwarded read data
//  cfg_rd_data_valid   in   1           read data valid (any latency >= 1 cycle)
//  irq_set             in   IRQ_WIDTH   per-source set pulses
//  interrupt           out  1           |(IRQ_STATUS & IRQ_ENABLE), registered
// BEHAVIOUR
//  Reset (reset_n low, async): all ready/valid/resp/rdata/cfg_* outputs 0, interrupt 0, CTRL/STATUS/ENABLE 0.
//  Map (addr[ADDR_WIDTH-1:4]==0 is local): 0x0 ID (RO), 0x4 CTRL (RW), 0x8 IRQ_STATUS (W1C), 0xC IRQ_ENABLE (RW,
//  low IRQ_WIDTH bits); else forwarded. Write to ID -> bresp SLVERR(2'b10), no state change.
//  Write FSM WR_IDLE->WR_EXEC->WR_RESP: in WR_IDLE awready/wready high until each channel captured; AW and W
//  accepted independently in any order/same cycle. Both held at edge N -> WR_EXEC in cycle N+1 (local update or
//  cfg_wr_en pulse, posted) -> bvalid from N+2, held with stable bresp until bready; then WR_IDLE.
//  Read FSM RD_IDLE->RD_EXEC->(RD_WAIT)->RD_RESP: arready high in RD_IDLE only. AR at edge N -> RD_EXEC cycle
//  N+1; local: rvalid from N+2 rresp OKAY; forwarded: cfg_rd_en pulse in N+1, RD_WAIT until cfg_rd_data_valid,
//  rvalid the cycle after valid with captured data. CFG_TIMEOUT cycles in RD_WAIT -> rvalid, rdata 0, SLVERR;
//  a late cfg_rd_data_valid in RD_IDLE/RD_RESP is dropped.
//  rvalid/rdata/rresp stable until rready. One outstanding transaction per direction.
//  Cfg bus arbitration: WR_EXEC and RD_EXEC same cycle -> write goes, read stalls one cycle in RD_EXEC.
//  While RD_WAIT pending, WR_EXEC to forwarded address stalls until read completes; local writes proceed.
//  IRQ_STATUS: irq_set same cycle as W1C of same bit -> set wins. interrupt updates cycle after status/enable.
//  Reset mid-transaction: FSMs to IDLE, response dropped; host must re-issue after reset.
// STRUCTURE
//  Package axil_cfg_pkg: register offsets, resp codes (OKAY=2'b00, SLVERR=2'b10), wr_state_t/rd_state_t enums.
//  Sub-module axil_cfg_reg_bank: local ID/CTRL/STATUS/ENABLE regs, W1C logic, interrupt register.
//  Top holds both channel FSMs, cfg arbitration, timeout counter ($clog2(CFG_TIMEOUT+1) bits, saturating).
// TESTING
//  1 AW and W same cycle, addr 0x4 data 0xA5A5_0001 -> bvalid 2 cycles later OKAY; read 0x4 returns 0xA5A5_0001.
//  2 W 3 cycles before AW, forwarded addr 0x100 -> single cfg_wr_en pulse addr 0x100 data matches; bresp OKAY.
//  3 read 0x200, model returns 0x1234_5678 after 5 cycles -> rvalid next cycle, rdata 0x1234_5678, OKAY;
//    rready low 4 cycles -> rvalid/rdata held stable.
//  4 read 0x300, model never answers -> rvalid at CFG_TIMEOUT+2 cycles after AR, rresp 2'b10, rdata 0.
//  5 ENABLE=0x1, irq_set=0x1 -> interrupt 1; W1C 0x8 data 0x1 same cycle as irq_set 0x1 -> stays set, interrupt 1.
//  6 write 0x0 -> bresp SLVERR, ID still reads 0x4741_524E; reset_n pulled mid RD_WAIT -> all outputs 0, new
//    read after reset completes OKAY.

Source files
------------

// File: rtl/axil_cfg_pkg.sv
// axil_cfg_pkg: shared register selects, AXI response codes and channel FSM states
package axil_cfg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] OFS_ID         = 4'h0;
    localparam logic [3:0] OFS_CTRL       = 4'h4;
    localparam logic [3:0] OFS_IRQ_STATUS = 4'h8;
    localparam logic [3:0] OFS_IRQ_ENABLE = 4'hC;

    localparam logic [1:0] SEL_ID     = OFS_ID[3:2];
    localparam logic [1:0] SEL_CTRL   = OFS_CTRL[3:2];
    localparam logic [1:0] SEL_STATUS = OFS_IRQ_STATUS[3:2];
    localparam logic [1:0] SEL_ENABLE = OFS_IRQ_ENABLE[3:2];

    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_EXEC, RD_WAIT, RD_RESP} rd_state_t;

endpackage

// File: rtl/axil_cfg_reg_bank.sv
// axil_cfg_reg_bank: local ID/CTRL/IRQ_STATUS/IRQ_ENABLE registers with W1C status and registered interrupt
module axil_cfg_reg_bank
    import axil_cfg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IRQ_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'h4741_524E
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [1:0]            wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [1:0]            rd_sel,
    input  logic [IRQ_WIDTH-1:0]  irq_set,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  interrupt
);

    logic [DATA_WIDTH-1:0] ctrl;
    logic [IRQ_WIDTH-1:0]  status;
    logic [IRQ_WIDTH-1:0]  enable;
    logic [IRQ_WIDTH-1:0]  w1c;

    // clear mask from a write to IRQ_STATUS; OR-ing irq_set afterwards makes a new set win
    always_comb begin
        w1c = (wr_en && wr_sel == SEL_STATUS) ? wr_data[IRQ_WIDTH-1:0] : '0;
    end

    // register updates; interrupt lags status/enable by one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl      <= '0;
            status    <= '0;
            enable    <= '0;
            interrupt <= 1'b0;
        end else begin
            if (wr_en && wr_sel == SEL_CTRL) ctrl <= wr_data;
            if (wr_en && wr_sel == SEL_ENABLE) enable <= wr_data[IRQ_WIDTH-1:0];
            status    <= (status & ~w1c) | irq_set;
            interrupt <= |(status & enable);
        end
    end

    // read mux over the four local words
    always_comb begin
        rd_data = rd_sel == SEL_ID     ? ID_VALUE :
                  rd_sel == SEL_CTRL   ? ctrl :
                  rd_sel == SEL_STATUS ? DATA_WIDTH'(status) :
                                         DATA_WIDTH'(enable);
    end

endmodule

// File: rtl/axil_cfg_responder.sv
// axil_cfg_responder: AXI4-Lite slave with a local register bank and a single-outstanding forwarded cfg bus
module axil_cfg_responder
    import axil_cfg_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    IRQ_WIDTH   = 4,
    parameter int                    CFG_TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'h4741_524E
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] axi4_slave_awaddr,
    input  logic                  axi4_slave_awvalid,
    output logic                  axi4_slave_awready,
    input  logic [DATA_WIDTH-1:0] axi4_slave_wdata,
    input  logic                  axi4_slave_wvalid,
    output logic                  axi4_slave_wready,
    output logic [1:0]            axi4_slave_bresp,
    output logic                  axi4_slave_bvalid,
    input  logic                  axi4_slave_bready,
    input  logic [ADDR_WIDTH-1:0] axi4_slave_araddr,
    input  logic                  axi4_slave_arvalid,
    output logic                  axi4_slave_arready,
    output logic [DATA_WIDTH-1:0] axi4_slave_rdata,
    output logic [1:0]            axi4_slave_rresp,
    output logic                  axi4_slave_rvalid,
    input  logic                  axi4_slave_rready,
    output logic                  cfg_wr_en,
    output logic                  cfg_rd_en,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [DATA_WIDTH-1:0] cfg_wr_data,
    input  logic [DATA_WIDTH-1:0] cfg_rd_data,
    input  logic                  cfg_rd_data_valid,
    input  logic [IRQ_WIDTH-1:0]  irq_set,
    output logic                  interrupt
);

    localparam int TW = $clog2(CFG_TIMEOUT + 1);

    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;
    logic                  live;
    logic                  aw_got, w_got;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data, bank_rd_data;
    logic [TW-1:0]         tmo_cnt;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_local, rd_local, wr_go, rd_go, bank_wr_en, tmo_hit;

    axil_cfg_reg_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .IRQ_WIDTH (IRQ_WIDTH),
        .ID_VALUE  (ID_VALUE)
    ) u_bank (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (bank_wr_en),
        .wr_sel   (aw_addr[3:2]),
        .wr_data  (w_data),
        .rd_sel   (ar_addr[3:2]),
        .irq_set  (irq_set),
        .rd_data  (bank_rd_data),
        .interrupt(interrupt)
    );

    // handshakes, cfg arbitration and request outputs; readies held low until the first edge after reset
    always_comb begin
        axi4_slave_awready = live && wr_state == WR_IDLE && !aw_got;
        axi4_slave_wready  = live && wr_state == WR_IDLE && !w_got;
        axi4_slave_arready = live && rd_state == RD_IDLE;
        axi4_slave_bvalid  = wr_state == WR_RESP;
        axi4_slave_rvalid  = rd_state == RD_RESP;
        aw_hs       = axi4_slave_awvalid && axi4_slave_awready;
        w_hs        = axi4_slave_wvalid && axi4_slave_wready;
        ar_hs       = axi4_slave_arvalid && axi4_slave_arready;
        wr_local    = aw_addr[ADDR_WIDTH-1:4] == '0;
        rd_local    = ar_addr[ADDR_WIDTH-1:4] == '0;
        wr_go       = wr_state == WR_EXEC && (wr_local || rd_state != RD_WAIT);
        rd_go       = rd_state == RD_EXEC && wr_state != WR_EXEC;
        cfg_wr_en   = wr_go && !wr_local;
        cfg_rd_en   = rd_go && !rd_local;
        cfg_addr    = cfg_wr_en ? aw_addr : cfg_rd_en ? ar_addr : '0;
        cfg_wr_data = cfg_wr_en ? w_data : '0;
        bank_wr_en  = wr_go && wr_local && aw_addr[3:2] != SEL_ID;
        tmo_hit     = tmo_cnt == TW'(CFG_TIMEOUT - 1);
    end

    // next-state logic for both channel FSMs
    always_comb begin
        wr_next = wr_state;
        rd_next = rd_state;
        if (wr_state == WR_IDLE && (aw_got || aw_hs) && (w_got || w_hs)) wr_next = WR_EXEC;
        if (wr_go) wr_next = WR_RESP;
        if (wr_state == WR_RESP && axi4_slave_bready) wr_next = WR_IDLE;
        if (ar_hs) rd_next = RD_EXEC;
        if (rd_go) rd_next = rd_local ? RD_RESP : RD_WAIT;
        if (rd_state == RD_WAIT && (cfg_rd_data_valid || tmo_hit)) rd_next = RD_RESP;
        if (rd_state == RD_RESP && axi4_slave_rready) rd_next = RD_IDLE;
    end

    // FSM state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
            live     <= 1'b0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            live     <= 1'b1;
        end
    end

    // channel capture, response registers and saturating read timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aw_got           <= 1'b0;
            w_got            <= 1'b0;
            aw_addr          <= '0;
            ar_addr          <= '0;
            w_data           <= '0;
            tmo_cnt          <= '0;
            axi4_slave_bresp <= RESP_OKAY;
            axi4_slave_rresp <= RESP_OKAY;
            axi4_slave_rdata <= '0;
        end else begin
            if (aw_hs) begin
                aw_got  <= 1'b1;
                aw_addr <= axi4_slave_awaddr;
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= axi4_slave_wdata;
            end
            if (wr_go) begin
                aw_got           <= 1'b0;
                w_got            <= 1'b0;
                axi4_slave_bresp <= (wr_local && aw_addr[3:2] == SEL_ID) ? RESP_SLVERR : RESP_OKAY;
            end
            if (ar_hs) ar_addr <= axi4_slave_araddr;
            if (rd_go && rd_local) begin
                axi4_slave_rdata <= bank_rd_data;
                axi4_slave_rresp <= RESP_OKAY;
            end
            if (rd_state == RD_WAIT && cfg_rd_data_valid) begin
                axi4_slave_rdata <= cfg_rd_data;
                axi4_slave_rresp <= RESP_OKAY;
            end else if (rd_state == RD_WAIT && tmo_hit) begin
                axi4_slave_rdata <= '0;
                axi4_slave_rresp <= RESP_SLVERR;
            end
            tmo_cnt <= rd_state != RD_WAIT ? '0 :
                       tmo_cnt == TW'(CFG_TIMEOUT) ? tmo_cnt : tmo_cnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_axil_cfg_responder.sv
// tb_axil_cfg_responder: directed vector table plus hand sequences for the AXI-Lite cfg responder
module tb_axil_cfg_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] awaddr, wdata, araddr, rdata, cfg_addr, cfg_wr_data, cfg_rd_data;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        cfg_wr_en, cfg_rd_en, cfg_rd_data_valid, interrupt;
    logic [3:0]  irq_set;

    int cmp_cnt = 0;
    int err_cnt = 0;

    int          mdl_lat = 0;
    logic [31:0] mdl_data = '0;
    int          mdl_cnt = -1;
    int          wr_pulses = 0, rd_pulses = 0, both_seen = 0;
    logic [31:0] wr_addr_seen, wr_data_seen, rd_addr_seen;

    always #5 clk = ~clk;

    axil_cfg_responder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .axi4_slave_awaddr (awaddr),
        .axi4_slave_awvalid(awvalid),
        .axi4_slave_awready(awready),
        .axi4_slave_wdata  (wdata),
        .axi4_slave_wvalid (wvalid),
        .axi4_slave_wready (wready),
        .axi4_slave_bresp  (bresp),
        .axi4_slave_bvalid (bvalid),
        .axi4_slave_bready (bready),
        .axi4_slave_araddr (araddr),
        .axi4_slave_arvalid(arvalid),
        .axi4_slave_arready(arready),
        .axi4_slave_rdata  (rdata),
        .axi4_slave_rresp  (rresp),
        .axi4_slave_rvalid (rvalid),
        .axi4_slave_rready (rready),
        .cfg_wr_en         (cfg_wr_en),
        .cfg_rd_en         (cfg_rd_en),
        .cfg_addr          (cfg_addr),
        .cfg_wr_data       (cfg_wr_data),
        .cfg_rd_data       (cfg_rd_data),
        .cfg_rd_data_valid (cfg_rd_data_valid),
        .irq_set           (irq_set),
        .interrupt         (interrupt)
    );

    // cfg fabric model: logs request pulses and answers reads mdl_lat cycles later (0 = never)
    initial begin
        cfg_rd_data_valid = 1'b0;
        cfg_rd_data       = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            cfg_rd_data_valid = 1'b0;
            cfg_rd_data       = 32'hBAD0_BAD0;
            if (cfg_wr_en) begin
                wr_pulses++;
                wr_addr_seen = cfg_addr;
                wr_data_seen = cfg_wr_data;
            end
            if (cfg_wr_en && cfg_rd_en) both_seen++;
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    cfg_rd_data_valid = 1'b1;
                    cfg_rd_data       = mdl_data;
                end
            end
            if (cfg_rd_en) begin
                rd_pulses++;
                rd_addr_seen = cfg_addr;
                if (mdl_lat > 0) mdl_cnt = mdl_lat;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // lat counts cycles from the cycle of the last address/data handshake to the first cycle with bvalid
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input int w_lead,
                             input logic [3:0] irq, output logic [1:0] resp, output int lat);
        int  n;
        logic ha, hw;
        n       = 0;
        awaddr  = a;
        wdata   = d;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        while ((awvalid || wvalid || n < w_lead) && n < 50) begin
            ha = awvalid && awready;
            hw = wvalid && wready;
            @(negedge clk);
            n++;
            if (ha) awvalid = 1'b0;
            if (hw) wvalid = 1'b0;
            if (n == w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat     = 1;
        irq_set = irq;
        @(negedge clk);
        irq_set = '0;
        lat     = 2;
        while (!bvalid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        resp  = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // lat counts cycles from the AR handshake cycle to the first cycle with rvalid; hold keeps rready low
    task automatic axi_read(input logic [31:0] a, input int hold,
                            output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n;
        n       = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        lat     = 1;
        while (!rvalid && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        d    = rdata;
        resp = rresp;
        repeat (hold) begin
            @(negedge clk);
            chk("rvalid_held", {31'b0, rvalid}, 32'd1);
            chk("rdata_held", rdata, d);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          lat;
    } vec_t;

    initial begin
        vec_t        v[11];
        logic [31:0] d;
        logic [1:0]  resp;
        int          lat, base;

        v[0]  = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 2'b00, 2};
        v[1]  = '{1'b0, 32'h0000_0004, 32'hA5A5_0001, 2'b00, 2};
        v[2]  = '{1'b0, 32'h0000_0000, 32'h4741_524E, 2'b00, 2};
        v[3]  = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 2'b10, 2};
        v[4]  = '{1'b0, 32'h0000_0000, 32'h4741_524E, 2'b00, 2};
        v[5]  = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 2'b00, 2};
        v[6]  = '{1'b0, 32'h0000_000C, 32'h0000_000F, 2'b00, 2};
        v[7]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 2'b00, 2};
        v[8]  = '{1'b0, 32'h0000_0400, 32'hC0DE_0400, 2'b00, 4};
        v[9]  = '{1'b1, 32'h0000_000C, 32'h0000_0000, 2'b00, 2};
        v[10] = '{1'b0, 32'h0000_0006, 32'hA5A5_0001, 2'b00, 2};

        reset_n = 1'b0;
        {awvalid, wvalid, bready, arvalid, rready} = '0;
        awaddr  = '0;
        wdata   = '0;
        araddr  = '0;
        irq_set = '0;
        repeat (3) @(negedge clk);
        chk("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
        chk("rst_valids", {27'b0, bvalid, rvalid, cfg_wr_en, cfg_rd_en, interrupt}, 32'd0);
        chk("rst_resps", {28'b0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_cfg_addr", cfg_addr, 32'd0);
        chk("rst_cfg_wr_data", cfg_wr_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        mdl_lat  = 2;
        mdl_data = 32'hC0DE_0400;
        for (int i = 0; i < 11; i++) begin
            if (v[i].wr) begin
                axi_write(v[i].addr, v[i].data, 0, 4'h0, resp, lat);
            end else begin
                axi_read(v[i].addr, 0, d, resp, lat);
                chk($sformatf("vec%0d_rdata", i), d, v[i].data);
            end
            chk($sformatf("vec%0d_resp", i), {30'b0, resp}, {30'b0, v[i].resp});
            chk($sformatf("vec%0d_lat", i), lat, v[i].lat);
        end

        base = wr_pulses;
        axi_write(32'h0000_0100, 32'h5555_AAAA, 3, 4'h0, resp, lat);
        chk("fwd_wr_pulses", wr_pulses - base, 32'd1);
        chk("fwd_wr_addr", wr_addr_seen, 32'h0000_0100);
        chk("fwd_wr_data", wr_data_seen, 32'h5555_AAAA);
        chk("fwd_wr_resp", {30'b0, resp}, 32'd0);

        mdl_lat  = 5;
        mdl_data = 32'h1234_5678;
        base     = rd_pulses;
        axi_read(32'h0000_0200, 4, d, resp, lat);
        chk("fwd_rd_data", d, 32'h1234_5678);
        chk("fwd_rd_resp", {30'b0, resp}, 32'd0);
        chk("fwd_rd_lat", lat, 32'd7);
        chk("fwd_rd_pulses", rd_pulses - base, 32'd1);
        chk("fwd_rd_addr", rd_addr_seen, 32'h0000_0200);

        mdl_lat = 0;
        axi_read(32'h0000_0300, 0, d, resp, lat);
        chk("tmo_resp", {30'b0, resp}, 32'd2);
        chk("tmo_rdata", d, 32'd0);
        chk("tmo_lat", lat, 32'd257);

        axi_write(32'h0000_000C, 32'h0000_0001, 0, 4'h0, resp, lat);
        irq_set = 4'h1;
        @(negedge clk);
        irq_set = 4'h0;
        repeat (2) @(negedge clk);
        chk("irq_raised", {31'b0, interrupt}, 32'd1);
        axi_write(32'h0000_0008, 32'h0000_0001, 0, 4'h1, resp, lat);
        repeat (2) @(negedge clk);
        chk("irq_set_wins", {31'b0, interrupt}, 32'd1);
        axi_read(32'h0000_0008, 0, d, resp, lat);
        chk("irq_status_kept", d, 32'd1);
        axi_write(32'h0000_0008, 32'h0000_0001, 0, 4'h0, resp, lat);
        repeat (2) @(negedge clk);
        chk("irq_cleared", {31'b0, interrupt}, 32'd0);

        araddr  = 32'h0000_0300;
        arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) @(negedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_readies", {29'b0, awready, wready, arready}, 32'd0);
        chk("midrst_valids", {27'b0, bvalid, rvalid, cfg_wr_en, cfg_rd_en, interrupt}, 32'd0);
        chk("midrst_rdata_resp", rdata | {28'b0, bresp, rresp}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        axi_read(32'h0000_0004, 0, d, resp, lat);
        chk("postrst_ctrl", d, 32'd0);
        chk("postrst_resp", {30'b0, resp}, 32'd0);
        chk("postrst_lat", lat, 32'd2);

        chk("cfg_never_both", both_seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
